// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush scheduler for the 5-stage RV32I pipeline.
// Merges D/E hazards with the M memory wait and the multi-cycle E divider.
module pipeline_stall_ctrl #(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             LoadUseD,
    input  logic             PCSrcE,
    input  logic             DivStartE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    input  logic             CountClear,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             FlushW,
    output logic             DivBusy,
    output logic             DivDoneE,
    output logic [CNT_W-1:0] StallCount
);

    localparam int CW = $clog2(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_CYCLES - 2);

    typedef enum logic {RUN, DIV_BUSY} state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] next_cnt;
    logic          mem_wait;
    logic          div_done;
    logic          div_hold;

    assign mem_wait = MemReqM & ~MemReadyM;
    assign div_done = (state == DIV_BUSY) & (cnt == '0) & ~mem_wait;
    assign div_hold = ((state == RUN) & DivStartE)
                    | ((state == DIV_BUSY) & ~div_done);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // A memory wait freezes both the start and the countdown of a divide.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        unique case (state)
            RUN: begin
                if (DivStartE && !mem_wait) begin
                    next_state = DIV_BUSY;
                    next_cnt   = CNT_LOAD;
                end
            end
            DIV_BUSY: begin
                if (!mem_wait) begin
                    if (cnt == '0) next_state = RUN;
                    else           next_cnt   = cnt - CW'(1);
                end
            end
        endcase
    end

    always_comb begin
        StallF   = 1'b0;
        StallD   = 1'b0;
        StallE   = 1'b0;
        StallM   = 1'b0;
        FlushD   = 1'b0;
        FlushE   = 1'b0;
        FlushM   = 1'b0;
        FlushW   = 1'b0;
        StallE   = mem_wait | div_hold;
        StallF   = StallE | LoadUseD;
        StallD   = StallF;
        StallM   = mem_wait;
        FlushD   = PCSrcE & ~StallE;
        FlushE   = (LoadUseD | PCSrcE) & ~StallE;
        FlushM   = div_hold & ~mem_wait;
        FlushW   = mem_wait;
        DivBusy  = (state == DIV_BUSY);
        DivDoneE = div_done;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          StallCount <= '0;
        else if (CountClear) StallCount <= '0;
        else if (StallF)     StallCount <= StallCount + CNT_W'(1);
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed scoreboard bench for pipeline_stall_ctrl (DIV_CYCLES=4, CNT_W=8).
module tb_pipeline_stall_ctrl;

    localparam int DIV_CYCLES = 4;
    localparam int CNT_W      = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic LoadUseD, PCSrcE, DivStartE, MemReqM, MemReadyM, CountClear;
    logic StallF, StallD, StallE, StallM;
    logic FlushD, FlushE, FlushM, FlushW;
    logic DivBusy, DivDoneE;
    logic [CNT_W-1:0] StallCount;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.DIV_CYCLES(DIV_CYCLES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .LoadUseD(LoadUseD), .PCSrcE(PCSrcE), .DivStartE(DivStartE),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM), .CountClear(CountClear),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
        .DivBusy(DivBusy), .DivDoneE(DivDoneE), .StallCount(StallCount)
    );

    typedef struct {
        string            tag;
        logic [9:0]       outs;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    // outs = {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushM,FlushW,DivBusy,DivDoneE}
    // in   = {rst_n,LoadUseD,PCSrcE,DivStartE,MemReqM,MemReadyM,CountClear}
    task automatic step(input string tag, input logic [6:0] in,
                        input logic [9:0] outs);
        exp_t e;
        exp_t got;
        logic [9:0] obs;
        @(posedge clk);
        #1;
        {rst_n, LoadUseD, PCSrcE, DivStartE, MemReqM, MemReadyM, CountClear} = in;
        if (!in[6]) exp_cnt = '0;
        e.tag  = tag;
        e.outs = outs;
        e.cnt  = exp_cnt;
        q.push_back(e);
        @(negedge clk);
        tests++;
        if (q.size() == 0) begin
            fails++;
            $error("FAIL %s scoreboard empty", tag);
            return;
        end
        got = q.pop_front();
        obs = {StallF, StallD, StallE, StallM, FlushD, FlushE,
               FlushM, FlushW, DivBusy, DivDoneE};
        assert (obs === got.outs) else begin
            fails++;
            $error("FAIL %s outs observed=%b expected=%b", got.tag, obs, got.outs);
        end
        tests++;
        assert (StallCount === got.cnt) else begin
            fails++;
            $error("FAIL %s count observed=%0d expected=%0d",
                   got.tag, StallCount, got.cnt);
        end
        if (!in[6] || in[0]) exp_cnt = '0;
        else if (outs[9])    exp_cnt = exp_cnt + CNT_W'(1);
    endtask

    initial begin
        rst_n = 1'b0;
        {LoadUseD, PCSrcE, DivStartE, MemReqM, MemReadyM, CountClear} = '0;

        step("reset",     7'b0_000000, 10'b0000_0000_00);
        step("idle",      7'b1_000000, 10'b0000_0000_00);
        step("loaduse",   7'b1_100000, 10'b1100_0100_00);
        step("idle1",     7'b1_000000, 10'b0000_0000_00);
        step("branch",    7'b1_010000, 10'b0000_1100_00);
        for (int i = 0; i < 3; i++)
            step("br_memw", 7'b1_010100, 10'b1111_0001_00);
        step("br_memok",  7'b1_010110, 10'b0000_1100_00);
        step("idle2",     7'b1_000000, 10'b0000_0000_00);

        step("div_c1",    7'b1_001000, 10'b1110_0010_00);
        step("div_c2",    7'b1_001000, 10'b1110_0010_10);
        step("div_c3",    7'b1_001000, 10'b1110_0010_10);
        step("div_c4",    7'b1_001000, 10'b0000_0000_11);
        step("div_after", 7'b1_000000, 10'b0000_0000_00);

        step("dm_c1",     7'b1_001000, 10'b1110_0010_00);
        step("dm_c2",     7'b1_001100, 10'b1111_0001_10);
        step("dm_c3",     7'b1_001100, 10'b1111_0001_10);
        step("dm_c4",     7'b1_001000, 10'b1110_0010_10);
        step("dm_c5",     7'b1_001000, 10'b1110_0010_10);
        step("dm_c6",     7'b1_001000, 10'b0000_0000_11);
        step("dm_after",  7'b1_000000, 10'b0000_0000_00);

        step("rw_c0",     7'b1_001100, 10'b1111_0001_00);
        step("rw_c1",     7'b1_001000, 10'b1110_0010_00);
        step("rw_c2",     7'b1_001000, 10'b1110_0010_10);
        step("rw_c3",     7'b1_001000, 10'b1110_0010_10);
        step("rw_c4",     7'b1_001000, 10'b0000_0000_11);

        step("rs_c1",     7'b1_001000, 10'b1110_0010_00);
        step("rs_c2",     7'b1_001000, 10'b1110_0010_10);
        step("rs_pulse",  7'b0_000000, 10'b0000_0000_00);
        step("rs_f1",     7'b1_001000, 10'b1110_0010_00);
        step("rs_f2",     7'b1_001000, 10'b1110_0010_10);
        step("rs_f3",     7'b1_001000, 10'b1110_0010_10);
        step("rs_f4",     7'b1_001000, 10'b0000_0000_11);
        step("rs_after",  7'b1_000000, 10'b0000_0000_00);

        step("clr",       7'b1_000001, 10'b0000_0000_00);
        for (int i = 0; i < 259; i++)
            step("wrap", 7'b1_100000, 10'b1100_0100_00);
        step("lu_clr",    7'b1_100001, 10'b1100_0100_00);
        step("post_clr",  7'b1_000000, 10'b0000_0000_00);
        step("final",     7'b1_000000, 10'b0000_0000_00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
